// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, redirect/stall
// handling, sticky misaligned-target flag and saturating stall/flush counters.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken_ex,
    input  logic [31:0] branch_target_ex,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_id,
    output logic [31:0] pc_plus4_id,
    output logic [31:0] instr_id,
    output logic        valid_id,
    output logic        misalign_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q,          pc_d;
    logic [31:0] pc_id_q,       pc_id_d;
    logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
    logic [31:0] instr_id_q,    instr_id_d;
    logic        valid_id_q,    valid_id_d;
    logic        misalign_q,    misalign_d;
    logic [15:0] stall_cnt_q,   stall_cnt_d;
    logic [15:0] flush_cnt_q,   flush_cnt_d;
    logic [31:0] pc_plus4;

    // Wraps modulo 2^32, so the top-of-memory word rolls over to address 0.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d          = pc_q;
        pc_id_d       = pc_id_q;
        pc_plus4_id_d = pc_plus4_id_q;
        instr_id_d    = instr_id_q;
        valid_id_d    = valid_id_q;
        misalign_d    = misalign_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;

        if (branch_taken_ex) begin
            // The wrong-path instruction is squashed; pc_id/pc_plus4_id keep their values.
            pc_d       = {branch_target_ex[31:2], 2'b00};
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
            if (branch_target_ex[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
            if (flush_cnt_q != 16'hFFFF) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end
        end else if (stall) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end else begin
            pc_d          = pc_plus4;
            pc_id_d       = pc_q;
            pc_plus4_id_d = pc_plus4;
            instr_id_d    = imem_rdata;
            valid_id_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC_ALIGNED;
            pc_id_q       <= 32'd0;
            pc_plus4_id_q <= 32'd0;
            instr_id_q    <= NOP_INSTR;
            valid_id_q    <= 1'b0;
            misalign_q    <= 1'b0;
            stall_cnt_q   <= 16'd0;
            flush_cnt_q   <= 16'd0;
        end else begin
            pc_q          <= pc_d;
            pc_id_q       <= pc_id_d;
            pc_plus4_id_q <= pc_plus4_id_d;
            instr_id_q    <= instr_id_d;
            valid_id_q    <= valid_id_d;
            misalign_q    <= misalign_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    // imem_addr comes straight from the PC flop, so stall/redirect never reach it combinationally.
    assign imem_addr    = pc_q;
    assign pc_id        = pc_id_q;
    assign pc_plus4_id  = pc_plus4_id_q;
    assign instr_id     = instr_id_q;
    assign valid_id     = valid_id_q;
    assign misalign_err = misalign_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a default-PC instance for the main scenarios and
// a second instance reset near the top of memory to exercise PC wrap.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic [31:0] imem_addr, imem_rdata, pc_id, pc_plus4_id, instr_id;
    logic        valid_id, misalign_err;
    logic [15:0] stall_cnt, flush_cnt;

    logic        stall_w, branch_w;
    logic [31:0] target_w;
    logic [31:0] imem_addr_w, imem_rdata_w, pc_id_w, pc_plus4_id_w, instr_id_w;
    logic        valid_id_w, misalign_err_w;
    logic [15:0] stall_cnt_w, flush_cnt_w;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] K = 32'hA5A5_0000;

    always #5 clk = ~clk;

    // Combinational instruction memory: the word at address A is A ^ K.
    assign imem_rdata   = imem_addr ^ K;
    assign imem_rdata_w = imem_addr_w ^ K;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken_ex(branch_taken_ex), .branch_target_ex(branch_target_ex),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pc_id(pc_id), .pc_plus4_id(pc_plus4_id), .instr_id(instr_id),
        .valid_id(valid_id), .misalign_err(misalign_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall_w),
        .branch_taken_ex(branch_w), .branch_target_ex(target_w),
        .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .pc_id(pc_id_w), .pc_plus4_id(pc_plus4_id_w), .instr_id(instr_id_w),
        .valid_id(valid_id_w), .misalign_err(misalign_err_w),
        .stall_cnt(stall_cnt_w), .flush_cnt(flush_cnt_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic e_valid, input logic [31:0] e_addr);
        check({tag, ".pc_id"},     pc_id,            e_pc);
        check({tag, ".instr_id"},  instr_id,         e_instr);
        check({tag, ".valid_id"},  {31'd0, valid_id}, {31'd0, e_valid});
        check({tag, ".imem_addr"}, imem_addr,        e_addr);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken_ex = 1'b0; branch_target_ex = 32'd0;
        stall_w = 1'b0; branch_w = 1'b0; target_w = 32'd0;
        step(); step();

        // Reset state
        check_ifid("rst", 32'd0, 32'h13, 1'b0, 32'd0);
        check("rst.pc_plus4_id", pc_plus4_id, 32'd0);
        check("rst.misalign", {31'd0, misalign_err}, 32'd0);
        check("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        check("wrap.rst.imem_addr", imem_addr_w, 32'hFFFF_FFF8);

        // Free run after reset
        rst = 1'b0;
        step();
        check_ifid("run1", 32'h0, 32'hA5A5_0000, 1'b1, 32'h4);
        check("run1.pc_plus4_id", pc_plus4_id, 32'h4);
        check("wrap1.imem_addr", imem_addr_w, 32'hFFFF_FFFC);
        check("wrap1.pc_id", pc_id_w, 32'hFFFF_FFF8);
        step();
        check_ifid("run2", 32'h4, 32'hA5A5_0004, 1'b1, 32'h8);
        check("wrap2.imem_addr", imem_addr_w, 32'h0000_0000);
        check("wrap2.pc_id", pc_id_w, 32'hFFFF_FFFC);
        check("wrap2.pc_plus4_id", pc_plus4_id_w, 32'h0000_0000);
        step();
        check_ifid("run3", 32'h8, 32'hA5A5_0008, 1'b1, 32'hC);

        // Stall for three cycles holds everything
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid("stall", 32'h8, 32'hA5A5_0008, 1'b1, 32'hC);
        end
        check("stall.cnt", {16'd0, stall_cnt}, 32'd3);
        stall = 1'b0;
        step();
        check_ifid("release", 32'hC, 32'hA5A5_000C, 1'b1, 32'h10);
        check("release.cnt", {16'd0, stall_cnt}, 32'd3);
        step();
        check("pre_br.imem_addr", imem_addr, 32'h14);

        // Taken branch from PC 0x14 to 0x100
        branch_taken_ex = 1'b1; branch_target_ex = 32'h100;
        step();
        check_ifid("br", 32'h10, 32'h13, 1'b0, 32'h100);
        check("br.pc_plus4_id", pc_plus4_id, 32'h14);
        check("br.flush_cnt", {16'd0, flush_cnt}, 32'd1);
        branch_taken_ex = 1'b0;
        step();
        check_ifid("br_tgt", 32'h100, 32'hA5A5_0100, 1'b1, 32'h104);

        // Stall and branch in the same cycle: branch wins, stall not counted
        stall = 1'b1; branch_taken_ex = 1'b1; branch_target_ex = 32'h40;
        step();
        check_ifid("st_br", 32'h100, 32'h13, 1'b0, 32'h40);
        check("st_br.stall_cnt", {16'd0, stall_cnt}, 32'd3);
        check("st_br.flush_cnt", {16'd0, flush_cnt}, 32'd2);
        stall = 1'b0; branch_taken_ex = 1'b0;
        step();
        check_ifid("st_br_tgt", 32'h40, 32'hA5A5_0040, 1'b1, 32'h44);

        // Back-to-back redirects
        branch_taken_ex = 1'b1; branch_target_ex = 32'h80;
        step();
        check_ifid("b2b1", 32'h40, 32'h13, 1'b0, 32'h80);
        branch_target_ex = 32'hC0;
        step();
        check_ifid("b2b2", 32'h40, 32'h13, 1'b0, 32'hC0);
        check("b2b.flush_cnt", {16'd0, flush_cnt}, 32'd4);
        branch_taken_ex = 1'b0;
        step();
        check_ifid("b2b_tgt", 32'hC0, 32'hA5A5_00C0, 1'b1, 32'hC4);
        check("b2b.misalign", {31'd0, misalign_err}, 32'd0);

        // Misaligned redirect target
        branch_taken_ex = 1'b1; branch_target_ex = 32'h202;
        step();
        check("mis.imem_addr", imem_addr, 32'h200);
        check("mis.flag", {31'd0, misalign_err}, 32'd1);
        branch_taken_ex = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mis.hold", {31'd0, misalign_err}, 32'd1);
        end
        check("mis.pc_id", pc_id, 32'h208);

        // Reset during a stall discards everything
        stall = 1'b1; rst = 1'b1;
        step();
        check_ifid("rst_stall", 32'd0, 32'h13, 1'b0, 32'd0);
        check("rst_stall.misalign", {31'd0, misalign_err}, 32'd0);
        check("rst_stall.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        check("rst_stall.stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // Long stall saturates the counter
        rst = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        check("sat.stall_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
        check_ifid("sat.hold", 32'd0, 32'h13, 1'b0, 32'd0);
        stall = 1'b0;
        step();
        check_ifid("sat.release", 32'd0, 32'hA5A5_0000, 1'b1, 32'h4);

        // Reset overrides a simultaneous redirect
        rst = 1'b1; branch_taken_ex = 1'b1; branch_target_ex = 32'h302;
        step();
        check_ifid("rst_br", 32'd0, 32'h13, 1'b0, 32'd0);
        check("rst_br.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        check("rst_br.misalign", {31'd0, misalign_err}, 32'd0);
        rst = 1'b0; branch_taken_ex = 1'b0;
        step();
        check_ifid("post_rst", 32'd0, 32'hA5A5_0000, 1'b1, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on reset or flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 stall  input  1  load-use stall from hazard detection; holds PC and IF/ID.
REQ-006 branch_taken_ex  input  1  EX-stage resolved taken branch/jump; redirects fetch.
REQ-007 branch_target_ex  input  32  redirect target address.
REQ-008 imem_addr  output  32  instruction memory address; equals current PC, combinational.
REQ-009 imem_rdata  input  32  instruction word; combinational read, valid in the same cycle as imem_addr.
REQ-010 pc_id  output  32  IF/ID register: PC of the instruction in ID.
REQ-011 pc_plus4_id  output  32  IF/ID register: pc_id + 4.
REQ-012 instr_id  output  32  IF/ID register: instruction in ID.
REQ-013 valid_id  output  1  IF/ID register: 1 = real instruction, 0 = bubble.
REQ-014 misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.
REQ-015 stall_cnt  output  16  count of cycles with an accepted stall; saturates at 16'hFFFF.
REQ-016 flush_cnt  output  16  count of accepted redirects; saturates at 16'hFFFF.

Function
REQ-017 PC register: 32 bits, word aligned; PC[1:0] always 0.
REQ-018 Per-cycle priority: rst > branch_taken_ex > stall > normal advance.
REQ-019 Normal advance (no rst/branch/stall): PC <= PC + 4; IF/ID <= {PC, PC+4, imem_rdata, valid=1}.
REQ-020 Stall (stall=1, branch_taken_ex=0): PC, pc_id, pc_plus4_id, instr_id, valid_id all hold; stall_cnt increments.
REQ-021 Redirect (branch_taken_ex=1): PC <= {branch_target_ex[31:2], 2'b00}; IF/ID <= {pc_id held, pc_plus4_id held, NOP_INSTR, valid=0}; flush_cnt increments; the stall input is ignored that cycle and stall_cnt does not increment.
REQ-022 Redirect with branch_target_ex[1:0] != 0: misalign_err <= 1 and stays 1 until rst; the redirect still proceeds with the low bits cleared.
REQ-023 Fetch latency: an instruction at address A presented on imem_addr in cycle N appears on instr_id in cycle N+1 when not stalled or flushed.
REQ-024 Taken-branch penalty: exactly one bubble (the wrong-path instruction in IF/ID); the target instruction reaches ID one cycle after the redirect cycle.
REQ-025 Back-to-back redirects: each is honoured in order; each inserts a bubble and increments flush_cnt.
REQ-026 Continuous stall: the state holds indefinitely with no lost instruction; advance resumes in the first cycle with stall=0.
REQ-027 PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000 (modulo 2^32); pc_plus4_id wraps the same way.
REQ-028 Counters: 16-bit, saturating; they do not wrap to 0.
REQ-029 No combinational path from stall or branch_taken_ex to imem_addr.

Reset
REQ-030 When rst=1 at a rising edge: PC <= RESET_PC; instr_id <= NOP_INSTR; valid_id <= 0; pc_id <= 0; pc_plus4_id <= 0; misalign_err <= 0; stall_cnt <= 0; flush_cnt <= 0.
REQ-031 rst overrides stall and branch_taken_ex in the same cycle.
REQ-032 Reset mid-stall or mid-redirect discards all in-flight state.
REQ-033 First cycle after rst deasserts: imem_addr = RESET_PC, valid_id = 0; valid_id = 1 one cycle later.

Verification
REQ-034 Reset then 3 free-running cycles with imem_rdata = addr^32'hA5A5_0000 -> instr_id sequence A5A5_0000, A5A5_0004, A5A5_0008; valid_id = 1 from cycle 2.
REQ-035 stall=1 for 3 cycles while instr_id = X at pc_id = 0x8 -> instr_id = X, pc_id = 0x8 and imem_addr = 0xC held for all 3 cycles; stall_cnt = 3; advance on release.
REQ-036 branch_taken_ex=1 with target 0x100 at PC 0x14 -> next cycle imem_addr = 0x100, instr_id = 0x13, valid_id = 0, flush_cnt = 1; the following cycle pc_id = 0x100.
REQ-037 stall=1 and branch_taken_ex=1 together, target 0x40 -> redirect to 0x40 and bubble; stall_cnt unchanged.
REQ-038 Redirect target 0x202 -> imem_addr = 0x200, misalign_err = 1 held through subsequent cycles until rst.
REQ-039 RESET_PC = 32'hFFFF_FFF8, run 3 cycles -> imem_addr 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; pc_plus4_id = 0 for the instruction at 0xFFFF_FFFC.
